// File: rtl/ad7276_pkg.sv
// Shared types and constants for the AD7276 sampling controller.
// The state encoding is one-hot; a beat is {tlast, tdata[15:0]}.
package ad7276_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_REQ     = 3'b010,
    ST_CAPTURE = 3'b100
  } state_t;

  localparam int CH_ID_BIT  = 15;
  localparam int SAMPLE_MSB = 11;
  localparam int BEAT_W     = 17;

  localparam int DEFAULT_MIN_PERIOD     = 199;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1023;
  localparam int DEFAULT_FIFO_DEPTH     = 4;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } beat_t;

  function automatic logic [15:0] beat_data(input logic ch, input logic [SAMPLE_MSB:0] sample);
    logic [15:0] d;
    d                = '0;
    d[CH_ID_BIT]     = ch;
    d[SAMPLE_MSB:0]  = sample;
    return d;
  endfunction

  function automatic logic [1:0] mask_popcount(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/ad7276_axis_fifo.sv
// Synchronous FIFO: push visible at the head one clock later; rd_dat is zero when empty.
// Backpressure: wr_rdy drops when full unless a pop happens in the same clock.
module ad7276_axis_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   free_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_fire;
  logic             rd_fire;

  assign rd_vld   = (count != '0);
  assign wr_rdy   = (count != CW'(DEPTH)) || rd_rdy;
  assign wr_fire  = wr_vld && wr_rdy;
  assign rd_fire  = rd_vld && rd_rdy;
  assign rd_dat   = rd_vld ? mem[rd_ptr] : '0;
  assign free_cnt = CW'(DEPTH) - count;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ad7276_sample_ctrl.sv
// AD7276 sampling controller: periodic/single ticks, request with timeout, tagged beats to AXI-Stream.
// Tick->adc_en 1 clk, rdy edge->first write 1 clk; a full FIFO drops the whole sample and counts it.
module ad7276_sample_ctrl
  import ad7276_pkg::*;
#(
  parameter int MIN_PERIOD     = DEFAULT_MIN_PERIOD,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
  input  logic        fpga_clk_i,
  input  logic        reset_i,
  input  logic        cfg_enable_i,
  input  logic        cfg_single_i,
  input  logic [1:0]  cfg_ch_mask_i,
  input  logic [15:0] cfg_period_i,
  input  logic        clear_status_i,
  output logic        adc_en_0_o,
  output logic        adc_en_1_o,
  input  logic        adc_data_rdy_i,
  input  logic [11:0] adc_data_0_i,
  input  logic [11:0] adc_data_1_i,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        overflow_o,
  output logic        timeout_o,
  output logic [15:0] drop_cnt_o
);
  localparam int          CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] MIN_P    = 16'(MIN_PERIOD);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [15:0]      tick_cnt;
  logic [15:0]      period;
  logic             tick;
  logic [1:0]       mask;
  logic [11:0]      data0;
  logic [11:0]      data1;
  logic             second;
  logic             second_n;
  logic [15:0]      tmo_cnt;
  logic             rdy_prev;
  logic             rdy_edge;
  logic [1:0]       adc_en;
  logic             overrun;
  logic             overflow;
  logic             timeout;
  logic [15:0]      drop_cnt;
  logic             load_mask;
  logic             load_data;
  logic             push;
  logic             drop;
  logic             set_timeout;
  logic             set_overrun;
  beat_t            push_beat;
  beat_t            head;
  logic             fifo_wr_vld;
  logic             fifo_wr_rdy;
  logic             fifo_rd_vld;
  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] need;

  // Tick generator: counter held at 0 while disabled so the first enabled clock ticks.
  assign period = (cfg_period_i < MIN_P) ? MIN_P : cfg_period_i;
  assign tick   = cfg_enable_i ? (tick_cnt == 16'd0) : cfg_single_i;

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i || !cfg_enable_i) begin
      tick_cnt <= 16'd0;
    end else if (tick) begin
      tick_cnt <= period;
    end else begin
      tick_cnt <= tick_cnt - 16'd1;
    end
  end

  assign rdy_edge    = adc_data_rdy_i && !rdy_prev;
  assign need        = CNT_W'(mask_popcount(mask));
  assign set_overrun = tick && (state != ST_IDLE);

  always_comb begin
    state_n     = state;
    second_n    = 1'b0;
    load_mask   = 1'b0;
    load_data   = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    set_timeout = 1'b0;
    push_beat   = '0;
    case (state)
      ST_IDLE: begin
        if (tick && (cfg_ch_mask_i != 2'b00)) begin
          load_mask = 1'b1;
          state_n   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (rdy_edge) begin
          load_data = 1'b1;
          state_n   = ST_CAPTURE;
        end else if (tmo_cnt == TMO_LAST) begin
          set_timeout = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        state_n = ST_IDLE;
        if (second) begin
          push           = 1'b1;
          push_beat.last = 1'b1;
          push_beat.data = beat_data(1'b1, data1);
        end else if (free_cnt < need) begin
          // Room is checked once for the whole sample, never beat by beat.
          drop = 1'b1;
        end else if (mask[0]) begin
          push           = 1'b1;
          push_beat.last = ~mask[1];
          push_beat.data = beat_data(1'b0, data0);
          if (mask[1]) begin
            second_n = 1'b1;
            state_n  = ST_CAPTURE;
          end
        end else begin
          push           = 1'b1;
          push_beat.last = 1'b1;
          push_beat.data = beat_data(1'b1, data1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      second   <= 1'b0;
      mask     <= 2'b00;
      data0    <= '0;
      data1    <= '0;
      tmo_cnt  <= '0;
      rdy_prev <= 1'b0;
      adc_en   <= 2'b00;
    end else begin
      state    <= state_n;
      second   <= second_n;
      rdy_prev <= adc_data_rdy_i;
      if (load_mask) begin
        mask <= cfg_ch_mask_i;
      end
      if (load_data) begin
        data0 <= adc_data_0_i;
        data1 <= adc_data_1_i;
      end
      if (load_mask) begin
        tmo_cnt <= '0;
      end else if (state == ST_REQ) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (state_n == ST_REQ) begin
        adc_en <= load_mask ? cfg_ch_mask_i : mask;
      end else begin
        adc_en <= 2'b00;
      end
    end
  end

  // Sticky status: an event in the same clock as a clear survives the clear.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      overrun  <= 1'b0;
      overflow <= 1'b0;
      timeout  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overrun  <= set_overrun || (overrun && !clear_status_i);
      overflow <= drop || (overflow && !clear_status_i);
      timeout  <= set_timeout || (timeout && !clear_status_i);
      if (drop) begin
        if (clear_status_i) begin
          drop_cnt <= 16'd1;
        end else if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end else if (clear_status_i) begin
        drop_cnt <= '0;
      end
    end
  end

  assign fifo_wr_vld = push && fifo_wr_rdy;

  ad7276_axis_fifo #(
    .WIDTH(BEAT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (fpga_clk_i),
    .reset   (reset_i),
    .wr_vld  (fifo_wr_vld),
    .wr_rdy  (fifo_wr_rdy),
    .wr_dat  (push_beat),
    .rd_vld  (fifo_rd_vld),
    .rd_rdy  (m_axis_tready),
    .rd_dat  (head),
    .free_cnt(free_cnt)
  );

  assign m_axis_tvalid = fifo_rd_vld;
  assign m_axis_tdata  = head.data;
  assign m_axis_tlast  = head.last;
  assign adc_en_0_o    = adc_en[0];
  assign adc_en_1_o    = adc_en[1];
  assign busy_o        = (state != ST_IDLE);
  assign overrun_o     = overrun;
  assign overflow_o    = overflow;
  assign timeout_o     = timeout;
  assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_ad7276_sample_ctrl.sv
// Directed bench for ad7276_sample_ctrl: single-shot vector table plus periodic,
// clamp/overrun, timeout, overflow and reset-in-capture sequences.
module tb_ad7276_sample_ctrl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cfg_enable_i = 1'b0;
  logic        cfg_single_i = 1'b0;
  logic [1:0]  cfg_ch_mask_i = 2'b00;
  logic [15:0] cfg_period_i = 16'd199;
  logic        clear_status_i = 1'b0;
  logic        adc_en_0_o, adc_en_1_o;
  logic        adc_data_rdy_i = 1'b0;
  logic [11:0] adc_data_0_i = '0;
  logic [11:0] adc_data_1_i = '0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        busy_o, overrun_o, overflow_o, timeout_o;
  logic [15:0] drop_cnt_o;

  ad7276_sample_ctrl dut (
    .fpga_clk_i    (clk),
    .reset_i       (reset_i),
    .cfg_enable_i  (cfg_enable_i),
    .cfg_single_i  (cfg_single_i),
    .cfg_ch_mask_i (cfg_ch_mask_i),
    .cfg_period_i  (cfg_period_i),
    .clear_status_i(clear_status_i),
    .adc_en_0_o    (adc_en_0_o),
    .adc_en_1_o    (adc_en_1_o),
    .adc_data_rdy_i(adc_data_rdy_i),
    .adc_data_0_i  (adc_data_0_i),
    .adc_data_1_i  (adc_data_1_i),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy_o        (busy_o),
    .overrun_o     (overrun_o),
    .overflow_o    (overflow_o),
    .timeout_o     (timeout_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [16:0] rx_q[$];
  always @(negedge clk) begin
    if (!reset_i && m_axis_tvalid && m_axis_tready) rx_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  typedef struct {
    logic [1:0]  mask;
    logic [11:0] d0;
    logic [11:0] d1;
    int          nbeats;
    logic [16:0] b0;
    logic [16:0] b1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_single();
    step();
    cfg_single_i = 1'b1;
    step();
    cfg_single_i = 1'b0;
  endtask

  task automatic pulse_rdy();
    step();
    adc_data_rdy_i = 1'b1;
    step();
    adc_data_rdy_i = 1'b0;
  endtask

  task automatic pulse_clear();
    step();
    clear_status_i = 1'b1;
    step();
    clear_status_i = 1'b0;
  endtask

  task automatic wait_en(output int t, input int bound);
    bit seen;
    seen = 1'b0;
    t = -1;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (adc_en_0_o || adc_en_1_o) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_adc_en actual=no_rise required=rise_within_%0d", bound);
    end
  endtask

  function automatic logic [31:0] q_at(input int k);
    return (k < rx_q.size()) ? {15'd0, rx_q[k]} : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=stuck required=finish");
    $fatal(1, "watchdog");
  end

  int t[3];
  int t0, t1, n_en;
  logic [11:0] d0s[3];
  logic [11:0] d1s[3];
  logic [16:0] exp_f[4];

  initial begin
    vecs[0] = '{2'b01, 12'hABC, 12'h123, 1, 17'h10ABC, 17'h00000};
    vecs[1] = '{2'b10, 12'hABC, 12'h456, 1, 17'h18456, 17'h00000};
    vecs[2] = '{2'b11, 12'h001, 12'hFFF, 2, 17'h00001, 17'h18FFF};
    vecs[3] = '{2'b00, 12'h555, 12'hAAA, 0, 17'h00000, 17'h00000};
    vecs[4] = '{2'b11, 12'hFFF, 12'h000, 2, 17'h00FFF, 17'h18000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_adc_en", {adc_en_1_o, adc_en_0_o}, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_busy", busy_o, 0);
    check("rst_flags", {overrun_o, overflow_o, timeout_o}, 0);
    check("rst_drop_cnt", drop_cnt_o, 0);
    step();
    reset_i = 1'b0;
    step(2);

    // Single-shot vector table; mask is changed right after the tick to prove it was latched
    for (int i = 0; i < 5; i++) begin
      rx_q.delete();
      cfg_ch_mask_i = vecs[i].mask;
      adc_data_0_i  = vecs[i].d0;
      adc_data_1_i  = vecs[i].d1;
      step();
      cfg_single_i = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_en_before_tick", i), {adc_en_1_o, adc_en_0_o}, 0);
      step();
      cfg_single_i  = 1'b0;
      cfg_ch_mask_i = ~vecs[i].mask;
      @(negedge clk);
      check($sformatf("vec%0d_en_after_tick", i), {adc_en_1_o, adc_en_0_o}, vecs[i].mask);
      step(3);
      pulse_rdy();
      step(8);
      @(negedge clk);
      check($sformatf("vec%0d_nbeats", i), rx_q.size(), vecs[i].nbeats);
      if (vecs[i].nbeats > 0) check($sformatf("vec%0d_beat0", i), q_at(0), vecs[i].b0);
      if (vecs[i].nbeats > 1) check($sformatf("vec%0d_beat1", i), q_at(1), vecs[i].b1);
      check($sformatf("vec%0d_idle", i), {busy_o, adc_en_1_o, adc_en_0_o}, 0);
    end

    // Periodic sampling, mask 11, period 199, rdy 50 clocks after each request
    rx_q.delete();
    cfg_ch_mask_i = 2'b11;
    cfg_period_i  = 16'd199;
    for (int s = 0; s < 3; s++) begin
      d0s[s] = 12'h100 + 12'(s);
      d1s[s] = 12'h200 + 12'(s);
    end
    step();
    cfg_enable_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      adc_data_0_i = d0s[s];
      adc_data_1_i = d1s[s];
      wait_en(t[s], 400);
      step(49);
      pulse_rdy();
      step(5);
    end
    cfg_enable_i = 1'b0;
    step(3);
    @(negedge clk);
    check("per_gap01", t[1] - t[0], 200);
    check("per_gap12", t[2] - t[1], 200);
    check("per_nbeats", rx_q.size(), 6);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("per_s%0d_ch0", s), q_at(2 * s), {5'b0, d0s[s]});
      check($sformatf("per_s%0d_ch1", s), q_at(2 * s + 1), {5'b11000, d1s[s]});
    end
    check("per_flags", {overrun_o, overflow_o, timeout_o}, 0);

    // Period clamp and overrun while rdy is held off
    rx_q.delete();
    cfg_period_i = 16'd10;
    step();
    cfg_enable_i = 1'b1;
    wait_en(t0, 50);
    step(5);
    pulse_rdy();
    wait_en(t1, 400);
    check("clamp_gap", t1 - t0, 200);
    step(400);
    @(negedge clk);
    check("ovr_busy", busy_o, 1);
    check("ovr_flag", overrun_o, 1);
    pulse_rdy();
    step(5);
    cfg_enable_i = 1'b0;
    step(3);
    @(negedge clk);
    check("ovr_nbeats", rx_q.size(), 4);
    pulse_clear();
    @(negedge clk);
    check("ovr_cleared", overrun_o, 0);

    // Timeout: rdy never rises
    rx_q.delete();
    cfg_ch_mask_i = 2'b01;
    pulse_single();
    n_en = 0;
    repeat (1100) begin
      @(negedge clk);
      if (adc_en_0_o) n_en++;
    end
    check("tmo_en_clocks", n_en, 1023);
    check("tmo_flag", timeout_o, 1);
    check("tmo_idle", {busy_o, adc_en_1_o, adc_en_0_o}, 0);
    check("tmo_nbeats", rx_q.size(), 0);
    pulse_clear();
    @(negedge clk);
    check("tmo_cleared", timeout_o, 0);

    // Overflow: tready low, two samples fill the FIFO, third is dropped
    rx_q.delete();
    m_axis_tready = 1'b0;
    cfg_ch_mask_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      adc_data_0_i = 12'h3A0 + 12'(k);
      adc_data_1_i = 12'h5B0 + 12'(k);
      pulse_single();
      step(3);
      if (k == 0) begin
        adc_data_rdy_i = 1'b1;
        step();
        @(negedge clk);
        check("lat_tvalid_edge_clk", m_axis_tvalid, 0);
        check("lat_en_fall", {adc_en_1_o, adc_en_0_o}, 0);
        step();
        @(negedge clk);
        check("lat_tvalid_plus2", m_axis_tvalid, 1);
        check("lat_head", {m_axis_tlast, m_axis_tdata}, 17'h003A0);
        adc_data_rdy_i = 1'b0;
      end else begin
        pulse_rdy();
      end
      step(6);
    end
    @(negedge clk);
    check("ovf_flag", overflow_o, 1);
    check("ovf_drop_cnt", drop_cnt_o, 1);
    check("ovf_head_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, 17'h003A0});
    exp_f[0] = 17'h003A0;
    exp_f[1] = 17'h185B0;
    exp_f[2] = 17'h003A1;
    exp_f[3] = 17'h185B1;
    step();
    m_axis_tready = 1'b1;
    step(10);
    @(negedge clk);
    check("ovf_drain_nbeats", rx_q.size(), 4);
    for (int k = 0; k < 4; k++) check($sformatf("ovf_drain_b%0d", k), q_at(k), exp_f[k]);

    // Reset while in CAPTURE
    rx_q.delete();
    m_axis_tready = 1'b0;
    pulse_single();
    step(3);
    adc_data_rdy_i = 1'b1;
    step();
    adc_data_rdy_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clk);
    check("cap_busy", busy_o, 1);
    step();
    @(negedge clk);
    check("cap_rst_outputs", {adc_en_1_o, adc_en_0_o, m_axis_tvalid, m_axis_tlast, busy_o}, 0);
    check("cap_rst_tdata", m_axis_tdata, 0);
    check("cap_rst_flags", {overrun_o, overflow_o, timeout_o}, 0);
    check("cap_rst_drop_cnt", drop_cnt_o, 0);
    step();
    reset_i = 1'b0;
    m_axis_tready = 1'b1;
    step(10);
    @(negedge clk);
    check("cap_rst_no_beats", rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad7276_sample_ctrl.md
# ad7276_sample_ctrl

Sampling controller for the AD7276 dual-channel serial interface. It generates conversion requests at a programmable rate, drives the interface enables, and waits for the ready indication with a timeout. Each completed sample is captured and packed as tagged AXI-Stream beats through a small FIFO, and the block reports overruns, drops and timeouts. It sits between the AXI-Lite register bank and the ADC interface, in the `fpga_clk_i` domain.

## Interface
- `MIN_PERIOD`, 199: smallest effective sample period, in clocks minus 1 (2 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 1023: maximum clocks spent in REQ before abort.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `fpga_clk_i` in 1: sole clock.
- `reset_i` in 1: reset, synchronous, active-high.
- `cfg_enable_i` in 1: periodic sampling enable.
- `cfg_single_i` in 1: one-clock pulse requesting one sample; honoured only when `cfg_enable_i`=0.
- `cfg_ch_mask_i` in 2: bit0 = channel 0, bit1 = channel 1.
- `cfg_period_i` in 16: sample period in clocks minus 1.
- `clear_status_i` in 1: clears sticky flags and `drop_cnt_o`.
- `adc_en_0_o`, `adc_en_1_o` out 1: conversion request to the interface.
- `adc_data_rdy_i` in 1: interface ready level, synchronous to `fpga_clk_i`.
- `adc_data_0_i`, `adc_data_1_i` in 12: sample words.
- `m_axis_tdata` out 16: {channel id[15], 3'b000, sample[11:0]}.
- `m_axis_tvalid` out 1, `m_axis_tlast` out 1, `m_axis_tready` in 1.
- `busy_o` out 1: FSM not in IDLE.
- `overrun_o`, `overflow_o`, `timeout_o` out 1: sticky flags.
- `drop_cnt_o` out 16: saturating count of dropped samples.

## Operation
- Tick generator:
  - Period P = max(`cfg_period_i`, `MIN_PERIOD`).
  - While `cfg_enable_i`=0 the counter is held at 0.
  - A tick fires in the first enabled clock, then every P+1 clocks; the counter reloads with P on each tick.
  - `cfg_single_i` with enable low produces one tick.
- FSM states: IDLE, REQ, CAPTURE.
  - IDLE→REQ on a tick with a nonzero mask. The mask is latched here, so later changes affect only the next sample. A tick with mask 00 is ignored.
  - REQ: `adc_en_n_o` = latched mask bits, registered. REQ→CAPTURE on a rising edge of `adc_data_rdy_i` (compared against a registered previous value); both data words are latched in that clock.
  - REQ→IDLE when `TIMEOUT_CYCLES` clocks elapse without an edge; sets `timeout_o` and writes nothing.
  - CAPTURE: the free-space check is made on entry. If free entries < popcount(mask), the whole sample is dropped: `overflow_o` is set, `drop_cnt_o`+1 (saturating at 0xFFFF), and the FSM returns to IDLE.
  - Otherwise one beat per clock is written, channel 0 first; `tlast` marks the last enabled channel. Then CAPTURE→IDLE.
- A tick arriving while not in IDLE is discarded and sets `overrun_o`.
- Deasserting `cfg_enable_i` mid-sample does not abort the sample; it completes.
- AXI-Stream:
  - Driven from the FIFO head.
  - `tdata`/`tlast` are stable while `tvalid`=1 and `tready`=0.
  - A push and a pop in the same clock are allowed when the FIFO is full.
- `clear_status_i` clears the sticky flags and the counter. If an event occurs in the same clock, the event wins.

## Timing
- Reset values: `adc_en_*_o`=0, `m_axis_tvalid`=0, `tlast`=0, `tdata`=0, `busy_o`=0, all flags 0, `drop_cnt_o`=0. The FIFO is flushed, the FSM goes to IDLE, and the tick counter is set to 0.
- Reset mid-REQ drops the enables the next clock; partial samples are discarded.
- Latency from tick to `adc_en` high: 1 clock.
- Latency from the rdy edge seen at clock N to the first write: N+1. `tvalid` rises at N+2 if the FIFO was empty.
- The two beats of a two-channel sample are written in consecutive clocks.
- `adc_en` falls in the clock after the rdy edge.

## Structure
- Shared package `ad7276_pkg`:
  - State encoding (one-hot, 3 bits).
  - Beat field positions (`CH_ID_BIT`=15, `SAMPLE_MSB`=11).
  - Default period and timeout constants.
- Sub-module `ad7276_axis_fifo`: synchronous FIFO with width 17, depth `FIFO_DEPTH`, and `free_cnt` output.
- Top level contains the tick counter, FSM, timeout counter and status logic.

## Test plan
- Enable, mask 11, period 199, rdy pulsed 50 clocks after each request → beats ch0/ch1 with `tlast` on ch1 every 200 clocks; flags stay 0.
- `cfg_period_i`=10 → ticks every 200 clocks (clamped to `MIN_PERIOD`). Rdy held off for 400 clocks → `overrun_o`=1.
- Rdy never asserted → REQ exits after 1023 clocks; `timeout_o`=1, no beats, `adc_en` low.
- `tready`=0, mask 11, FIFO depth 4 → 2 samples stored, 3rd dropped; `overflow_o`=1, `drop_cnt_o`=1; samples drain intact once `tready`=1.
- Mask 01, `cfg_single_i` pulse with enable low, data 0xABC → single beat 0x0ABC with `tlast`=1.
- Assert reset while in CAPTURE → outputs at reset values the next clock; no further beats.
